// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the sequential multiply/divide unit: ALU control codes,
// MIPS HI/LO operation codes and controller states.
package muldiv_seq_pkg;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NEG_A  = 3'd1,
    NEG_B  = 3'd2,
    ITER   = 3'd3,
    FIX_LO = 3'd4,
    FIX_HI = 3'd5,
    DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/alu2.sv
// Gate-level 32-bit ALU: ripple-carry adder with a/b invert controls,
// AND/OR/ADD/SUB/SLT/NOR selected by the classic 4-bit MIPS control code.
module alu2 (
  input  logic [3:0]  ctl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);

  logic [31:0] ax;
  logic [31:0] bx;
  logic [31:0] sum;
  logic        c;
  logic        ovf;

  assign ax = a ^ {32{ctl[3]}};
  assign bx = b ^ {32{ctl[2]}};

  // b-invert doubles as the carry-in so SUB forms a + ~b + 1
  always_comb begin
    c   = ctl[2];
    sum = '0;
    for (int i = 0; i < 32; i++) begin
      sum[i] = ax[i] ^ bx[i] ^ c;
      c      = (ax[i] & bx[i]) | (c & (ax[i] ^ bx[i]));
    end
  end

  assign ovf = (ax[31] ~^ bx[31]) & (sum[31] ^ ax[31]);

  always_comb begin
    case (ctl[1:0])
      2'b00:   result = ax & bx;
      2'b01:   result = ax | bx;
      2'b10:   result = sum;
      default: result = {31'b0, sum[31] ^ ovf};
    endcase
  end

  assign zero = (result == 32'b0);

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU unit. A single alu2 instance is the only
// adder; operand magnitudes, shift-add / restoring-divide steps and sign fixups
// are all sequenced through it, giving a fixed 37-cycle latency.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        lo_zero_q, lo_zero_d;
  logic        busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [3:0]  alu_ctl;
  logic [31:0] alu_x, alu_y, alu_res;
  logic        alu_zero;

  logic        is_div, is_signed, b_zero;
  logic        neg_prod, neg_quo, neg_rem;
  logic [31:0] r_shift;
  logic        r_msb, borrow, accept, mul_carry;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign b_zero    = is_div & (b_q == 32'b0);
  assign neg_prod  = is_signed & ~is_div & (sign_a_q ^ sign_b_q);
  assign neg_quo   = is_signed & is_div & (sign_a_q ^ sign_b_q) & ~b_zero;
  assign neg_rem   = is_signed & is_div & sign_a_q & ~b_zero;

  assign r_shift   = {acc_hi_q[30:0], acc_lo_q[31]};
  assign r_msb     = acc_hi_q[31];
  assign borrow    = (~alu_x[31] & alu_y[31]) | (~(alu_x[31] ^ alu_y[31]) & alu_res[31]);
  assign accept    = r_msb | ~borrow;
  assign mul_carry = (alu_x[31] & alu_y[31]) | ((alu_x[31] | alu_y[31]) & ~alu_res[31]);

  alu2 u_alu (
    .ctl    (alu_ctl),
    .a      (alu_x),
    .b      (alu_y),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_comb begin
    alu_ctl = CTL_ADD;
    alu_x   = '0;
    alu_y   = '0;
    case (state_q)
      NEG_A: begin alu_ctl = CTL_SUB; alu_y = a_q; end
      NEG_B: begin alu_ctl = CTL_SUB; alu_y = b_q; end
      ITER: begin
        if (is_div) begin
          alu_ctl = CTL_SUB; alu_x = r_shift;  alu_y = mag_b_q;
        end else begin
          alu_ctl = CTL_ADD; alu_x = acc_hi_q; alu_y = mag_a_q;
        end
      end
      FIX_LO: begin alu_ctl = CTL_SUB; alu_y = acc_lo_q; end
      FIX_HI: begin
        // 64-bit negate high word: ~hi plus the carry out of (0 - lo)
        if (is_div) begin
          alu_ctl = CTL_SUB; alu_y = acc_hi_q;
        end else begin
          alu_ctl = CTL_ADD; alu_x = ~acc_hi_q; alu_y = {31'b0, lo_zero_q};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    lo_zero_d = lo_zero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          dbz_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = NEG_A;
        end
      end
      NEG_A: begin
        sign_a_d = is_signed & a_q[31];
        mag_a_d  = sign_a_d ? alu_res : a_q;
        state_d  = NEG_B;
      end
      NEG_B: begin
        sign_b_d = is_signed & b_q[31];
        mag_b_d  = sign_b_d ? alu_res : b_q;
        acc_hi_d = '0;
        acc_lo_d = is_div ? mag_a_q : mag_b_d;
        cnt_d    = '0;
        state_d  = ITER;
      end
      ITER: begin
        if (is_div) begin
          acc_hi_d = accept ? alu_res : r_shift;
          acc_lo_d = {acc_lo_q[30:0], accept};
        end else if (acc_lo_q[0]) begin
          acc_hi_d = {mul_carry, alu_res[31:1]};
          acc_lo_d = {alu_res[0], acc_lo_q[31:1]};
        end else begin
          acc_hi_d = {1'b0, acc_hi_q[31:1]};
          acc_lo_d = {acc_hi_q[0], acc_lo_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) state_d = FIX_LO;
      end
      FIX_LO: begin
        if (neg_prod | neg_quo) acc_lo_d = alu_res;
        lo_zero_d = alu_zero;
        state_d   = FIX_HI;
      end
      FIX_HI: begin
        if (neg_prod | neg_rem) acc_hi_d = alu_res;
        hi_d    = b_zero ? a_q : acc_hi_d;
        lo_d    = b_zero ? 32'hFFFF_FFFF : acc_lo_q;
        dbz_d   = b_zero;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      lo_zero_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      lo_zero_q <= lo_zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: a behavioural HI/LO model feeds a queue at
// each start; entries are popped and compared when done pulses.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  typedef struct packed {
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t r;
    logic signed [63:0] sx, sy, ps;
    logic [63:0] ux, uy, pu;
    logic signed [31:0] dx, dy;
    r = '0;
    case (o)
      2'b00: begin
        sx = $signed(x); sy = $signed(y); ps = sx * sy;
        r.hi = ps[63:32]; r.lo = ps[31:0];
      end
      2'b01: begin
        ux = {32'b0, x}; uy = {32'b0, y}; pu = ux * uy;
        r.hi = pu[63:32]; r.lo = pu[31:0];
      end
      default: begin
        if (y == 32'b0) begin
          r.dbz = 1'b1; r.hi = x; r.lo = 32'hFFFF_FFFF;
        end else if (o == 2'b10 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          r.hi = 32'h0; r.lo = 32'h8000_0000;
        end else if (o == 2'b10) begin
          dx = $signed(x); dy = $signed(y);
          r.lo = dx / dy; r.hi = dx % dy;
        end else begin
          r.lo = x / y; r.hi = x % y;
        end
      end
    endcase
    return r;
  endfunction

  // mode 0: plain; 1: extra starts at cycles 5 and 20; 2: start during done cycle
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int mode);
    int   cyc;
    int   extra;
    bit   seen;
    res_t e;
    sb_q.push_back(model(o, x, y));
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    seen = 1'b0;
    chk("dbz_clr", 64'(div_by_zero), 64'd0);
    while (!seen && cyc < 100) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        chk("busy", 64'(busy), 64'd1);
        chk("hold_hi", 64'(hi), 64'(last_hi));
        chk("hold_lo", 64'(lo), 64'(last_lo));
        if (mode == 1 && (cyc == 5 || cyc == 20)) begin
          start = 1'b1; op = ~o; a = ~x; b = y + 32'd1;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      chk("done_timeout", 64'd0, 64'd1);
      return;
    end
    chk("latency", 64'(cyc), 64'd37);
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 64'd0, 64'd1);
      return;
    end
    e = sb_q.pop_front();
    chk("hi", 64'(hi), 64'(e.hi));
    chk("lo", 64'(lo), 64'(e.lo));
    chk("dbz", 64'(div_by_zero), 64'(e.dbz));
    last_hi = e.hi;
    last_lo = e.lo;
    if (mode == 2) begin
      start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    chk("hi_hold_after", 64'(hi), 64'(last_hi));
    chk("dbz_hold", 64'(div_by_zero), 64'(e.dbz));
    if (mode != 0) begin
      extra = 0;
      for (int k = 0; k < 45; k++) begin
        if (done) extra++;
        @(posedge clk); #1;
      end
      chk("extra_done", 64'(extra), 64'd0);
      chk("busy_idle", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int cyc;
    int extra;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(2'b00, 32'd0, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'b11, 32'd100, 32'd7, 0);
    run_op(2'b11, 32'd5, 32'd0, 0);
    run_op(2'b01, 32'd2, 32'd3, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'd17, 32'd0, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 2);
    run_op(2'b01, 32'd1234, 32'd5678, 1);

    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(ro, rx, ry, 0);
    end

    // abort mid-operation: no done may follow and outputs clear at once
    run_op(2'b01, 32'd11, 32'd13, 0);
    op = 2'b01; a = 32'd77; b = 32'd99; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (cyc = 1; cyc < 13; cyc++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk("abort_no_done", 64'(extra), 64'd0);
    run_op(2'b01, 32'd4, 32'd5, 0);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
